// File: rtl/nexys_starship_monster_sched.sv
// Central monster scheduler. It spawns monsters at the four ship stations,
// runs a per-station attack timer, marks stations broken when a timer expires,
// counts kills, and ends the game once enough stations are broken.
`timescale 1ns/1ps
module nexys_starship_monster_sched #(
    parameter logic [7:0] SPAWN_MIN    = 8'd40,
    parameter logic [7:0] SPAWN_MASK   = 8'd63,
    parameter logic [7:0] ATTACK_TICKS = 8'd200,
    parameter logic [2:0] BREAK_LIMIT  = 3'd2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       play_flag,
    input  logic       tick,
    input  logic [3:0] kill,
    output logic [3:0] monster_ctrl,
    output logic [3:0] broken,
    output logic [7:0] score,
    output logic       game_over,
    output logic       busy
);

    localparam int unsigned NST     = 4;
    localparam int unsigned SPAWN_W = 9;   // SPAWN_MIN + masked LFSR can exceed 255
    localparam int unsigned ATK_W   = 8;

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t                      state, state_n;
    logic [15:0]                 lfsr, lfsr_n;
    logic [SPAWN_W-1:0]          spawn_cnt, spawn_n, spawn_load;
    logic [NST-1:0][ATK_W-1:0]   atk_cnt, atk_n;
    logic [NST-1:0]              mon_n, brk_n, kill_v;
    logic [7:0]                  score_n;
    logic [8:0]                  score_sum;
    logic                        go_n, busy_n, found;
    logic [1:0]                  idx;

    function automatic logic [2:0] pop4(input logic [3:0] v);
        pop4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    // Fibonacci LFSR step (taps 16,14,13,11) and spawn interval reload value
    always_comb begin
        lfsr_n     = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        spawn_load = SPAWN_W'(SPAWN_MIN) + SPAWN_W'(lfsr[7:0] & SPAWN_MASK);
    end

    // Next-state logic: kills, attack timers, spawn attempts, game-over detection
    always_comb begin
        state_n   = state;
        spawn_n   = spawn_cnt;
        atk_n     = atk_cnt;
        mon_n     = monster_ctrl;
        brk_n     = broken;
        score_n   = score;
        kill_v    = '0;
        score_sum = '0;
        found     = 1'b0;
        idx       = '0;

        case (state)
            IDLE: begin
                if (play_flag) begin
                    state_n = RUN;
                    spawn_n = spawn_load;
                end
            end
            RUN: begin
                // Kills only count against occupied stations
                kill_v    = kill & monster_ctrl;
                mon_n     = monster_ctrl & ~kill_v;
                score_sum = 9'(score) + 9'(pop4(kill_v));
                score_n   = score_sum[8] ? 8'hFF : score_sum[7:0];

                if (tick) begin
                    // A kill this cycle overrides timer expiry
                    for (int i = 0; i < NST; i++) begin
                        if (monster_ctrl[i] && !kill_v[i]) begin
                            if (atk_cnt[i] != '0) begin
                                atk_n[i] = atk_cnt[i] - ATK_W'(1);
                            end else begin
                                brk_n[i] = 1'b1;
                                mon_n[i] = 1'b0;
                            end
                        end
                    end

                    if (spawn_cnt != '0) begin
                        spawn_n = spawn_cnt - SPAWN_W'(1);
                    end else begin
                        // Round-robin search from a random station; dropped if none free
                        spawn_n = spawn_load;
                        for (int k = 0; k < NST; k++) begin
                            idx = lfsr[1:0] + 2'(k);
                            if (!found && !monster_ctrl[idx] && !broken[idx] && !kill[idx]) begin
                                found      = 1'b1;
                                mon_n[idx] = 1'b1;
                                atk_n[idx] = ATTACK_TICKS - ATK_W'(1);
                            end
                        end
                    end
                end

                if (pop4(brk_n) >= BREAK_LIMIT) begin
                    state_n = OVER;
                    mon_n   = '0;
                end
            end
            OVER: begin
                mon_n = '0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        go_n   = (state_n == OVER);
        busy_n = (state_n == RUN);
    end

    // State and output registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            lfsr         <= 16'hACE1;
            spawn_cnt    <= '0;
            atk_cnt      <= '0;
            monster_ctrl <= '0;
            broken       <= '0;
            score        <= '0;
            game_over    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            lfsr         <= lfsr_n;
            spawn_cnt    <= spawn_n;
            atk_cnt      <= atk_n;
            monster_ctrl <= mon_n;
            broken       <= brk_n;
            score        <= score_n;
            game_over    <= go_n;
            busy         <= busy_n;
        end
    end

endmodule

// File: tb/tb_nexys_starship_monster_sched.sv
// Bench for the monster scheduler: two instances with different timing
// parameters, a cycle model feeding a scoreboard queue, plus directed checks.
`timescale 1ns/1ps
module tb_nexys_starship_monster_sched;

    typedef struct packed {
        logic [1:0]       st;     // 0 idle, 1 run, 2 over
        logic [15:0]      lfsr;
        logic [8:0]       spawn;
        logic [3:0][7:0]  atk;
        logic [3:0]       mon;
        logic [3:0]       brk;
        logic [7:0]       score;
    } model_t;

    logic       Clk = 1'b0;
    logic       tick;
    logic       rst_a, play_a, go_a, busy_a;
    logic       rst_b, play_b, go_b, busy_b;
    logic [3:0] kill_a, mon_a, brk_a, kill_b, mon_b, brk_b;
    logic [7:0] score_a, score_b;

    model_t      ma, mb;
    logic [31:0] sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 Clk = ~Clk;

    nexys_starship_monster_sched #(
        .SPAWN_MIN(8'd2), .SPAWN_MASK(8'd0), .ATTACK_TICKS(8'd3), .BREAK_LIMIT(3'd2)
    ) dut_a (
        .Clk(Clk), .Reset(rst_a), .play_flag(play_a), .tick(tick), .kill(kill_a),
        .monster_ctrl(mon_a), .broken(brk_a), .score(score_a), .game_over(go_a), .busy(busy_a)
    );

    nexys_starship_monster_sched #(
        .SPAWN_MIN(8'd2), .SPAWN_MASK(8'd0), .ATTACK_TICKS(8'd20), .BREAK_LIMIT(3'd4)
    ) dut_b (
        .Clk(Clk), .Reset(rst_b), .play_flag(play_b), .tick(tick), .kill(kill_b),
        .monster_ctrl(mon_b), .broken(brk_b), .score(score_b), .game_over(go_b), .busy(busy_b)
    );

    function automatic model_t m_reset();
        model_t m;
        m      = '0;
        m.lfsr = 16'hACE1;
        return m;
    endfunction

    // One clock of expected behaviour
    function automatic model_t m_step(model_t m, logic rst, logic play, logic tk,
                                      logic [3:0] kl, int smin, int smask, int atk, int blim);
        model_t     n;
        int         inc, sc, nb;
        logic [1:0] j;
        logic       placed;
        if (rst) return m_reset();
        n      = m;
        n.lfsr = {m.lfsr[14:0], m.lfsr[15] ^ m.lfsr[13] ^ m.lfsr[12] ^ m.lfsr[10]};
        if (m.st == 2'd0) begin
            if (play) begin
                n.st    = 2'd1;
                n.spawn = 9'(smin + (int'(m.lfsr[7:0]) & smask));
            end
        end else if (m.st == 2'd1) begin
            inc = 0;
            for (int i = 0; i < 4; i++)
                if (kl[i] && m.mon[i]) begin
                    n.mon[i] = 1'b0;
                    inc++;
                end
            sc      = int'(m.score) + inc;
            n.score = (sc > 255) ? 8'd255 : 8'(sc);
            if (tk) begin
                for (int i = 0; i < 4; i++)
                    if (m.mon[i] && !kl[i]) begin
                        if (m.atk[i] != 8'd0) n.atk[i] = m.atk[i] - 8'd1;
                        else begin
                            n.brk[i] = 1'b1;
                            n.mon[i] = 1'b0;
                        end
                    end
                if (m.spawn != 9'd0) n.spawn = m.spawn - 9'd1;
                else begin
                    n.spawn = 9'(smin + (int'(m.lfsr[7:0]) & smask));
                    placed  = 1'b0;
                    for (int k = 0; k < 4; k++) begin
                        j = 2'((int'(m.lfsr[1:0]) + k) % 4);
                        if (!placed && !m.mon[j] && !m.brk[j] && !kl[j]) begin
                            placed   = 1'b1;
                            n.mon[j] = 1'b1;
                            n.atk[j] = 8'(atk - 1);
                        end
                    end
                end
            end
            nb = 0;
            for (int i = 0; i < 4; i++) nb += int'(n.brk[i]);
            if (nb >= blim) begin
                n.st  = 2'd2;
                n.mon = '0;
            end
        end
        return n;
    endfunction

    function automatic logic [31:0] m_out(model_t m);
        return 32'({m.mon, m.brk, m.score, m.st == 2'd2, m.st == 2'd1});
    endfunction

    function automatic int pop(logic [3:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: push model expectations, then pop and compare after the edge
    task automatic step();
        ma = m_step(ma, rst_a, play_a, tick, kill_a, 2, 0, 3, 2);
        mb = m_step(mb, rst_b, play_b, tick, kill_b, 2, 0, 20, 4);
        sb_q.push_back(m_out(ma));
        sb_q.push_back(m_out(mb));
        @(posedge Clk);
        #1;
        check("A_cycle", 32'({mon_a, brk_a, score_a, go_a, busy_a}), sb_q.pop_front());
        check("B_cycle", 32'({mon_b, brk_b, score_b, go_b, busy_b}), sb_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int         s, issued;
        logic [1:0] cand;
        rst_a = 1'b1; rst_b = 1'b1; play_a = 1'b0; play_b = 1'b0;
        tick = 1'b1; kill_a = '0; kill_b = '0;
        ma = m_reset(); mb = m_reset();

        // Reset state
        #2;
        check("A_reset", 32'({mon_a, brk_a, score_a, go_a, busy_a}), 32'd0);
        check("B_reset", 32'({mon_b, brk_b, score_b, go_b, busy_b}), 32'd0);
        step(); step();
        rst_a = 1'b0; rst_b = 1'b0;

        // Idle for 100 cycles; LFSR tracks the model and never hits zero
        for (int c = 0; c < 100; c++) begin
            step();
            check("A_lfsr", 32'(dut_a.lfsr), 32'(ma.lfsr));
            check("A_lfsr_nz", 32'(dut_a.lfsr != 16'd0), 32'd1);
        end

        // Start game A; first spawn three ticks into RUN
        play_a = 1'b1;
        step();
        play_a = 1'b0;
        check("A_busy", 32'(busy_a), 32'd1);
        step(); step();
        check("A_no_early_spawn", 32'(mon_a), 32'd0);
        cand = ma.lfsr[1:0];
        step();
        check("A_first_spawn", 32'(mon_a), 32'(4'b0001 << cand));

        // Unkilled monster breaks its station three ticks later
        s = int'(cand);
        step(); step();
        check("A_still_present", 32'(mon_a[s]), 32'd1);
        step();
        check("A_break", 32'({brk_a[s], mon_a[s]}), 32'b10);

        // Pause the game clock, then run until the second break
        tick = 1'b0;
        repeat (4) step();
        tick = 1'b1;
        for (int g = 0; g < 100 && !go_a; g++) step();
        check("A_over", 32'({go_a, busy_a, mon_a}), 32'b10_0000);
        check("A_over_brk", 32'(pop(brk_a)), 32'd2);
        kill_a = 4'hF;
        repeat (5) step();
        kill_a = '0;
        check("A_over_kill_ignored", 32'(score_a), 32'd0);

        // Kill on the expiry tick wins over the break
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        play_a = 1'b1;
        step();
        play_a = 1'b0;
        for (int g = 0; g < 50 && ma.mon == 4'd0; g++) step();
        s = 0;
        for (int i = 3; i >= 0; i--) if (ma.mon[i]) s = i;
        for (int g = 0; g < 20 && ma.atk[s] != 8'd0; g++) step();
        check("A_pre_kill_present", 32'(mon_a[s]), 32'd1);
        kill_a = 4'(4'b0001 << s);
        step();
        kill_a = '0;
        check("A_kill_vs_expiry", 32'({brk_a[s], mon_a[s], score_a}), 32'd1);

        // Game B: fill all four stations, then an attempt must be dropped
        play_b = 1'b1;
        step();
        play_b = 1'b0;
        for (int g = 0; g < 100 && mb.mon != 4'hF; g++) step();
        check("B_full", 32'(mon_b), 32'hF);
        for (int g = 0; g < 10 && mb.spawn != 9'd0; g++) step();
        step();
        check("B_full_drop", 32'(mon_b), 32'hF);
        check("B_reload", 32'(dut_b.spawn_cnt), 32'd2);

        // Simultaneous kills add together
        kill_b = 4'hF;
        step();
        kill_b = '0;
        check("B_multi_kill", 32'({mon_b, score_b}), 32'd4);

        // Score saturates at 255 after 260 kills
        issued = 4;
        for (int g = 0; g < 5000 && issued < 260; g++) begin
            kill_b = mb.mon;
            issued += pop(mb.mon);
            step();
        end
        kill_b = '0;
        check("B_saturate", 32'(score_b), 32'd255);

        // Asynchronous reset with three monsters active
        for (int g = 0; g < 100 && pop(mb.mon) != 3; g++) step();
        check("B_three_active", 32'(pop(mon_b)), 32'd3);
        #2 rst_b = 1'b1;
        #1;
        check("B_async_reset", 32'({mon_b, brk_b, score_b, go_b, busy_b}), 32'd0);
        mb = m_reset();
        step();
        rst_b = 1'b0;
        step();
        check("B_idle_after_reset", 32'({go_b, busy_b}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
